// File: rtl/fetch_unit_pkg.sv
// Shared pipeline types for the fetch stage and the branch checker.
// Holds the PC-select encoding, the reset PC and the fetch FSM/output types.
package fetch_unit_pkg;

    localparam logic [63:0] PC_INIT_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        PC_From_add4    = 2'd0,
        PC_From_add_imm = 2'd1,
        PC_From_jalr    = 2'd2
    } PcSelect;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_out_t;

    function automatic logic [63:0] pc_add4(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_target_gen.sv
// Redirect target computation from branch-resolution operands.
// Purely combinational so a future branch predictor can reuse it.
module pc_target_gen
    import fetch_unit_pkg::*;
(
    input  PcSelect     br_pc_select,
    input  logic [63:0] br_pc,
    input  logic [63:0] br_imm,
    input  logic [63:0] br_rs1,
    output logic [63:0] target
);

    logic [63:0] jalr_sum;

    assign jalr_sum = br_rs1 + br_imm;

    always_comb begin
        target = pc_add4(br_pc);
        case (br_pc_select)
            PC_From_add4:    target = pc_add4(br_pc);
            PC_From_add_imm: target = br_pc + br_imm;
            PC_From_jalr:    target = {jalr_sum[63:1], 1'b0};
            default:         target = pc_add4(br_pc);
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding bus request, a single output
// register for decode, and redirect/squash on branch resolution.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no request on the bus; waits for a free output slot or flush
// FETCH   | request at req_addr outstanding on the bus
// DISCARD | wrong-path request still outstanding; its response is dropped
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] PC_INIT = PC_INIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_flush,
    input  PcSelect     br_pc_select,
    input  logic [63:0] br_pc,
    input  logic [63:0] br_imm,
    input  logic [63:0] br_rs1,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    fetch_state_t state, state_next;
    logic [63:0]  pc, pc_next;
    logic [63:0]  req_addr, req_addr_next;
    fetch_out_t   out_q, out_next;
    logic [63:0]  target;
    logic         load;

    pc_target_gen u_target (
        .br_pc_select (br_pc_select),
        .br_pc        (br_pc),
        .br_imm       (br_imm),
        .br_rs1       (br_rs1),
        .target       (target)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= PC_INIT;
            req_addr <= PC_INIT;
            out_q    <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            req_addr <= req_addr_next;
            out_q    <= out_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        load          = 1'b0;

        case (state)
            IDLE: begin
                if (br_flush) begin
                    pc_next       = target;
                    req_addr_next = target;
                    state_next    = FETCH;
                end else if (!out_q.valid || if_ready) begin
                    req_addr_next = pc;
                    state_next    = FETCH;
                end
            end
            FETCH: begin
                if (iresp_data_ok && !br_flush) begin
                    load       = 1'b1;
                    pc_next    = pc_add4(pc);
                    state_next = IDLE;
                end else if (br_flush && iresp_data_ok) begin
                    pc_next       = target;
                    req_addr_next = target;
                end else if (br_flush) begin
                    // The bus cannot cancel, so the old address stays up.
                    pc_next    = target;
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (iresp_data_ok) begin
                    pc_next       = br_flush ? target : pc;
                    req_addr_next = br_flush ? target : pc;
                    state_next    = FETCH;
                end else if (br_flush) begin
                    pc_next = target;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A flush squashes the held instruction even if decode takes it this cycle.
    always_comb begin
        out_next = out_q;
        if (load) begin
            out_next.valid = 1'b1;
            out_next.pc    = req_addr;
            out_next.instr = iresp_data;
        end else if (br_flush || if_ready) begin
            out_next.valid = 1'b0;
        end
    end

    assign ireq_valid = (state != IDLE);
    assign ireq_addr  = req_addr;
    assign if_valid   = out_q.valid;
    assign if_pc      = out_q.pc;
    assign if_instr   = out_q.instr;

endmodule
